data_ram_pipe: RTL and testbench

DATA_RAM_PIPE -- requirements
Module: data_ram_pipe

---
 rtl/data_ram_pipe_pkg.sv | 46 ++++
 rtl/data_ram_pipe_if.sv | 30 +++
 rtl/dmem_rsp_fifo.sv | 68 ++++++
 rtl/data_ram_pipe.sv | 114 +++++++++++
 tb/tb_data_ram_pipe.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/data_ram_pipe_pkg.sv
// Shared defines for the data RAM pipe: default geometry, handshake polarity,
// pipeline control payload and the byte-select legality helper.
package data_ram_pipe_pkg;

  localparam int unsigned DMEM_DATA_W = 32;
  localparam int unsigned DMEM_DEPTH  = 1024;
  localparam int unsigned DMEM_RD_LAT = 2;

  localparam logic VALID_ON = 1'b1;
  localparam logic READY_ON = 1'b1;

  // Widest lane count the legality helper handles (DATA_W up to 512).
  localparam int unsigned MAX_LANES = 64;

  typedef struct packed {
    logic vld;
    logic err;
  } pipe_ctl_t;

  // Legal: a naturally aligned power-of-two lane group inside the word whose
  // first lane matches the byte offset of the address.
  function automatic logic sel_legal(input logic [MAX_LANES-1:0] sel,
                                     input int unsigned          nlanes,
                                     input int unsigned          addr_lo);
    int unsigned      lo;
    int unsigned      n;
    logic             found;
    logic [MAX_LANES-1:0] mask;
    lo    = 0;
    n     = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      if (sel[i]) begin
        n = n + 1;
        if (!found) begin
          lo    = i;
          found = 1'b1;
        end
      end
    end
    mask = ((MAX_LANES'(1) << n) - MAX_LANES'(1)) << lo;
    return (n != 0) && ((n & (n - 1)) == 0) && (sel == mask) &&
           ((lo & (n - 1)) == 0) && ((lo + n) <= nlanes) && (addr_lo == lo);
  endfunction

endpackage

// File: rtl/data_ram_pipe_if.sv
// Request/response bus of the data RAM pipe; master drives requests, slave
// (the RAM) drives responses.
interface data_ram_pipe_if
  import data_ram_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DMEM_DATA_W
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [31:0]           req_addr;
  logic [DATA_W/8-1:0]   req_sel;
  logic [DATA_W-1:0]     req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_sel, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_sel, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_rsp_fifo.sv
// Small circular response FIFO; the caller guarantees no push when full and
// no pop when empty. Output word reads as zero while empty.
module dmem_rsp_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] slot_q [DEPTH];
  logic [WIDTH-1:0] slot_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    slot_d = slot_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    if (push) begin
      slot_d[wr_q] = push_data;
      wr_d         = ptr_inc(wr_q);
    end
    if (pop) begin
      rd_d = ptr_inc(rd_q);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    valid_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) slot_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign valid = valid_q;
  assign data  = valid_q ? slot_q[rd_q] : '0;

endmodule

// File: rtl/data_ram_pipe.sv
// Byte-lane data RAM with fixed-latency read pipeline, credit-guarded response
// FIFO and optional alignment check (enabled by DMEM_ALIGN_CHK_EN).
module data_ram_pipe
  import data_ram_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DMEM_DATA_W,
  parameter int unsigned DEPTH  = DMEM_DEPTH,
  parameter int unsigned RD_LAT = DMEM_RD_LAT
) (
  input logic             clk,
  input logic             rst,
  data_ram_pipe_if.slave  bus
);

  localparam int unsigned NB     = DATA_W / 8;
  localparam int unsigned LANE_W = $clog2(NB);
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned FIFO_D = RD_LAT + 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_D + 1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept_c;
  logic              pop_c;
  logic              err_c;
  logic [IDX_W-1:0]  idx_c;
  logic              unused_addr_c;

  pipe_ctl_t         ctl_q  [RD_LAT];
  pipe_ctl_t         ctl_d  [RD_LAT];
  logic [DATA_W-1:0] data_q [RD_LAT];
  logic [DATA_W-1:0] data_d [RD_LAT];

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;

  logic              fifo_valid;
  logic [DATA_W:0]   fifo_data;

  assign idx_c         = bus.req_addr[IDX_W+LANE_W-1:LANE_W];
  assign unused_addr_c = ^{bus.req_addr[31:IDX_W+LANE_W], bus.req_addr[LANE_W-1:0]};
  assign accept_c      = (bus.req_valid == VALID_ON) && (ready_q == READY_ON);
  assign pop_c         = (fifo_valid == VALID_ON) && (bus.rsp_ready == READY_ON);

`ifdef DMEM_ALIGN_CHK_EN
  assign err_c = !sel_legal(MAX_LANES'(bus.req_sel), NB, 32'(bus.req_addr[LANE_W-1:0]));
`else
  assign err_c = 1'b0;
`endif

  // Writes land at the accepting edge, so a read one cycle later sees them.
  always_ff @(posedge clk) begin
    if (accept_c && bus.req_we && !err_c) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (bus.req_sel[i]) mem[idx_c][8*i +: 8] <= bus.req_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    ctl_d[0].vld = accept_c;
    ctl_d[0].err = err_c;
    data_d[0]    = (accept_c && !bus.req_we && !err_c) ? mem[idx_c] : '0;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      ctl_d[i]  = ctl_q[i-1];
      data_d[i] = data_q[i-1];
    end
  end

  // Credits count accepted-but-unpopped requests, bounding FIFO occupancy.
  always_comb begin
    case ({accept_c, pop_c})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    ready_d = (cnt_d < CNT_W'(FIFO_D)) ? READY_ON : ~READY_ON;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        ctl_q[i]  <= '0;
        data_q[i] <= '0;
      end
      cnt_q   <= '0;
      ready_q <= ~READY_ON;
    end else begin
      ctl_q   <= ctl_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  dmem_rsp_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_D)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (ctl_q[RD_LAT-1].vld),
    .push_data ({ctl_q[RD_LAT-1].err, data_q[RD_LAT-1]}),
    .pop       (pop_c),
    .valid     (fifo_valid),
    .data      (fifo_data)
  );

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = fifo_valid;
  assign bus.rsp_rdata = fifo_data[DATA_W-1:0];
  assign bus.rsp_err   = fifo_data[DATA_W];

endmodule

// File: tb/tb_data_ram_pipe.sv
// Scoreboard bench for data_ram_pipe: a word model predicts every response at
// acceptance; a negedge monitor pops and compares responses.
module tb_data_ram_pipe;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned RD_LAT = 2;
`ifdef DMEM_ALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    bit          lat;
    int          acc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;
  exp_t sb [$];
  logic [31:0] model [DEPTH];

  data_ram_pipe_if #(.DATA_W(DATA_W)) bus ();

  data_ram_pipe #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Response monitor: pops on handshake, checks held data while stalled.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_rsp", 64'(bus.rsp_rdata), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
          check_eq("rsp_err", 64'(bus.rsp_err), 64'(e.err));
          if (e.lat) check_eq("rsp_latency", 64'(cyc - e.acc), 64'(RD_LAT));
        end
      end else if (bus.rsp_valid && !bus.rsp_ready && sb.size() != 0) begin
        check_eq("rsp_hold", 64'(bus.rsp_rdata), 64'(sb[0].rdata));
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                       input logic [31:0] wd, input bit bad);
    exp_t        e;
    int          n;
    int unsigned idx;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_sel   = sel;
    bus.req_wdata = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.req_ready && n < 100);
    if (!bus.req_ready) begin
      check_eq("accept_timeout", 64'(0), 64'(1));
    end else begin
      idx     = (addr >> 2) % DEPTH;
      e.rdata = '0;
      e.err   = bad;
      e.lat   = bus.rsp_ready;
      e.acc   = cyc + 1;
      if (!we && !bad) e.rdata = model[idx];
      if (we && !bad) begin
        for (int i = 0; i < 4; i++)
          if (sel[i]) model[idx][8*i +: 8] = wd[8*i +: 8];
      end
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    check_eq("drain", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    rst           = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_sel   = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_req_ready", 64'(bus.req_ready), 64'(0));
    check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check_eq("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'(0));
    check_eq("rst_rsp_err", 64'(bus.rsp_err), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("post_rst_ready", 64'(bus.req_ready), 64'(1));

    // Full write then back-to-back read of the same word.
    issue(1'b1, 32'h10, 4'b1111, 32'hDEAD_BEEF, 1'b0);
    issue(1'b0, 32'h10, 4'b1111, 32'h0, 1'b0);
    wait_drain();

    // Single-lane merge.
    issue(1'b1, 32'h10, 4'b0100, 32'h00AA_0000, CHK);
    issue(1'b0, 32'h10, 4'b1111, 32'h0, 1'b0);
    wait_drain();

    // Address wrap modulo DEPTH, both directions.
    issue(1'b1, 32'h8, 4'b1111, 32'hCAFE_F00D, 1'b0);
    issue(1'b0, 32'(4*DEPTH + 8), 4'b1111, 32'h0, 1'b0);
    issue(1'b1, 32'(4*DEPTH + 12), 4'b1111, 32'h0BAD_F00D, 1'b0);
    issue(1'b0, 32'hC, 4'b1111, 32'h0, 1'b0);
    wait_drain();

    // sel = 0 write changes nothing.
    issue(1'b1, 32'h10, 4'b0000, 32'hFFFF_FFFF, CHK);
    issue(1'b0, 32'h10, 4'b1111, 32'h0, 1'b0);
    wait_drain();

    // Misaligned two-lane group.
    issue(1'b1, 32'h20, 4'b1111, 32'h1122_3344, 1'b0);
    issue(1'b1, 32'h21, 4'b0110, 32'h00BB_CC00, CHK);
    issue(1'b0, 32'h20, 4'b1111, 32'h0, 1'b0);
    wait_drain();

    // Burst of writes and reads with random data.
    for (int i = 0; i < 8; i++) issue(1'b1, 32'(4*(16+i)), 4'b1111, $urandom, 1'b0);
    for (int i = 0; i < 8; i++) issue(1'b0, 32'(4*(16+i)), 4'b1111, 32'h0, 1'b0);
    wait_drain();

    // Backpressure: credits stop accepts at RD_LAT+1.
    for (int i = 0; i < 4; i++) issue(1'b1, 32'(4*(4+i)), 4'b1111, 32'h5000_0000 + 32'(i), 1'b0);
    wait_drain();
    bus.rsp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = 32'(4*(4+(acc%4)));
      bus.req_sel   = 4'b1111;
      @(negedge clk);
      if (bus.req_ready) begin
        exp_t e;
        e.rdata = model[4+(acc%4)];
        e.err   = 1'b0;
        e.lat   = 1'b0;
        e.acc   = cyc + 1;
        sb.push_back(e);
        acc++;
      end
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    check_eq("bp_accepts", 64'(acc), 64'(RD_LAT + 1));
    check_eq("bp_ready_low", 64'(bus.req_ready), 64'(0));
    bus.rsp_ready = 1'b1;
    wait_drain();

    // Reset with two reads in flight.
    issue(1'b0, 32'h10, 4'b1111, 32'h0, 1'b0);
    issue(1'b0, 32'h8, 4'b1111, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    check_eq("pre_rst_valid", 64'(bus.rsp_valid), 64'(1));
    rst = 1'b0;
    #1;
    check_eq("mid_rst_valid", 64'(bus.rsp_valid), 64'(0));
    check_eq("mid_rst_ready", 64'(bus.req_ready), 64'(0));
    check_eq("mid_rst_rdata", 64'(bus.rsp_rdata), 64'(0));
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check_eq("after_rst_valid", 64'(bus.rsp_valid), 64'(0));
    check_eq("after_rst_ready", 64'(bus.req_ready), 64'(1));

    // Memory survives reset.
    issue(1'b0, 32'h10, 4'b1111, 32'h0, 1'b0);
    issue(1'b0, 32'h20, 4'b1111, 32'h0, 1'b0);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
